// File: rtl/mdom_wvb_hdr_arb_unpack_if.sv
// Unpacked waveform-buffer header bus: registered fields plus valid/ready handshake.
// The arbiter/unpacker drives it as master; the readout/event builder consumes it as slave.
interface mdom_wvb_hdr_arb_unpack_if #(
    parameter int LTC_W  = 49,
    parameter int ADDR_W = 10,
    parameter int CH_W   = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_chan;
    logic [LTC_W-1:0]  evt_ltc;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] stop_addr;
    logic [1:0]        trig_src;
    logic              cnst_run;
    logic [4:0]        pre_conf;
    logic              sync_rdy;
    logic [18:0]       bsum;
    logic [2:0]        bsum_len_sel;
    logic              bsum_valid;
    logic              local_coinc;
    logic              partial_wfm;
    logic              continued_wfm;
    logic [ADDR_W:0]   wfm_len;

    modport master (
        output out_valid, out_chan, evt_ltc, start_addr, stop_addr, trig_src, cnst_run,
               pre_conf, sync_rdy, bsum, bsum_len_sel, bsum_valid, local_coinc,
               partial_wfm, continued_wfm, wfm_len,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_chan, evt_ltc, start_addr, stop_addr, trig_src, cnst_run,
               pre_conf, sync_rdy, bsum, bsum_len_sel, bsum_valid, local_coinc,
               partial_wfm, continued_wfm, wfm_len,
        output out_ready
    );
endinterface

// File: rtl/mdom_wvb_hdr_arb_unpack.sv
// Round-robin arbiter over NUM_CH show-ahead header FIFOs; the winning header is unpacked
// into a one-deep output register with waveform length and per-channel continuation check.
module mdom_wvb_hdr_arb_unpack #(
    parameter int NUM_CH = 24,
    parameter int LTC_W  = 49,
    parameter int ADDR_W = 10,
    parameter int CH_W   = 5,
    localparam int HDR_W = LTC_W + 2*ADDR_W + 35
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*HDR_W-1:0] hdr_in,
    input  logic [NUM_CH-1:0]       hdr_valid,
    output logic [NUM_CH-1:0]       hdr_rdreq,
    mdom_wvb_hdr_arb_unpack_if.master ob,
    output logic [NUM_CH-1:0]       seq_err,
    input  logic                    err_clr,
    output logic [31:0]             hdr_cnt
);
    typedef struct packed {
        logic              continued_wfm;
        logic              partial_wfm;
        logic              local_coinc;
        logic              bsum_valid;
        logic [2:0]        bsum_len_sel;
        logic [18:0]       bsum;
        logic              sync_rdy;
        logic [4:0]        pre_conf;
        logic              cnst_run;
        logic [1:0]        trig_src;
        logic [ADDR_W-1:0] stop_addr;
        logic [ADDR_W-1:0] start_addr;
        logic [LTC_W-1:0]  evt_ltc;
    } hdr_t;

    hdr_t [NUM_CH-1:0] hdr_arr;
    hdr_t              sel;
    hdr_t              hdr_q;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   chan_q;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   len_q;
    logic              vld_q;
    logic              load;
    logic [NUM_CH-1:0] exp_cont;
    logic [NUM_CH-1:0] err_set;

    assign hdr_arr = hdr_in;

    // Search starts one past the last winner, so the last winner is the lowest priority.
    always_comb begin
        logic [CH_W:0] idx;
        logic          found;
        grant = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
            if (!found && hdr_valid[idx[CH_W-1:0]]) begin
                grant = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign load = (!vld_q || ob.out_ready) && (|hdr_valid);
    assign sel  = hdr_arr[grant];
    assign span = sel.stop_addr - sel.start_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            hdr_q   <= '0;
            chan_q  <= '0;
            len_q   <= '0;
            rr_ptr  <= CH_W'(NUM_CH-1);
            hdr_cnt <= '0;
        end else begin
            if (load) begin
                vld_q  <= 1'b1;
                hdr_q  <= sel;
                chan_q <= grant;
                len_q  <= {1'b0, span} + (ADDR_W+1)'(1);
                rr_ptr <= grant;
            end else if (ob.out_ready) begin
                vld_q  <= 1'b0;
            end
            if (vld_q && ob.out_ready && hdr_cnt != '1) hdr_cnt <= hdr_cnt + 32'd1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign hdr_rdreq[k] = load && (grant == CH_W'(k));
        assign err_set[k]   = hdr_rdreq[k] && (sel.continued_wfm != exp_cont[k]);

        // A new error on this channel wins over a concurrent clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                exp_cont[k] <= 1'b0;
                seq_err[k]  <= 1'b0;
            end else begin
                if (hdr_rdreq[k]) exp_cont[k] <= sel.partial_wfm;
                if (err_set[k])   seq_err[k]  <= 1'b1;
                else if (err_clr) seq_err[k]  <= 1'b0;
            end
        end
    end

    assign ob.out_valid     = vld_q;
    assign ob.out_chan      = chan_q;
    assign ob.wfm_len       = len_q;
    assign ob.evt_ltc       = hdr_q.evt_ltc;
    assign ob.start_addr    = hdr_q.start_addr;
    assign ob.stop_addr     = hdr_q.stop_addr;
    assign ob.trig_src      = hdr_q.trig_src;
    assign ob.cnst_run      = hdr_q.cnst_run;
    assign ob.pre_conf      = hdr_q.pre_conf;
    assign ob.sync_rdy      = hdr_q.sync_rdy;
    assign ob.bsum          = hdr_q.bsum;
    assign ob.bsum_len_sel  = hdr_q.bsum_len_sel;
    assign ob.bsum_valid    = hdr_q.bsum_valid;
    assign ob.local_coinc   = hdr_q.local_coinc;
    assign ob.partial_wfm   = hdr_q.partial_wfm;
    assign ob.continued_wfm = hdr_q.continued_wfm;
endmodule

// File: tb/tb_mdom_wvb_hdr_arb_unpack.sv
// Bench for the header arbiter/unpacker: queue-modelled FIFOs feed the DUT and a
// transaction-level reference tracks grants, delivered headers, counters and sequence errors.
module tb_mdom_wvb_hdr_arb_unpack;
    localparam int NUM_CH = 24;
    localparam int LTC_W  = 49;
    localparam int ADDR_W = 10;
    localparam int CH_W   = 5;
    localparam int HDR_W  = 104;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_CH*HDR_W-1:0] hdr_in;
    logic [NUM_CH-1:0]       hdr_valid;
    logic [NUM_CH-1:0]       hdr_rdreq;
    logic [NUM_CH-1:0]       seq_err;
    logic                    err_clr;
    logic [31:0]             hdr_cnt;

    mdom_wvb_hdr_arb_unpack_if #(.LTC_W(LTC_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) ob ();

    mdom_wvb_hdr_arb_unpack #(.NUM_CH(NUM_CH), .LTC_W(LTC_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .hdr_in    (hdr_in),
        .hdr_valid (hdr_valid),
        .hdr_rdreq (hdr_rdreq),
        .ob        (ob),
        .seq_err   (seq_err),
        .err_clr   (err_clr),
        .hdr_cnt   (hdr_cnt)
    );

    logic [HDR_W-1:0] fifo [NUM_CH][$];
    int checks   = 0;
    int failures = 0;

    // Reference state: what the output register should hold, expressed per transaction.
    int                m_rr;
    bit                m_ov;
    logic [HDR_W-1:0]  m_hdr;
    int                m_chan;
    logic [NUM_CH-1:0] m_exp_cont;
    logic [NUM_CH-1:0] m_seq_err;
    logic [31:0]       m_cnt;

    task automatic refresh();
        for (int k = 0; k < NUM_CH; k++) begin
            hdr_valid[k] = (fifo[k].size() != 0);
            hdr_in[k*HDR_W +: HDR_W] = (fifo[k].size() != 0) ? fifo[k][0] : '0;
        end
    endtask

    task automatic push(input int ch, input logic [HDR_W-1:0] h);
        fifo[ch].push_back(h);
        refresh();
    endtask

    task automatic flush();
        for (int k = 0; k < NUM_CH; k++) fifo[k].delete();
        refresh();
    endtask

    task automatic model_reset();
        m_rr = NUM_CH - 1; m_ov = 1'b0; m_hdr = '0; m_chan = 0;
        m_exp_cont = '0; m_seq_err = '0; m_cnt = '0;
    endtask

    function automatic logic [HDR_W-1:0] mk(input int s, input int e, input bit part, input bit cont);
        logic [127:0]     r;
        logic [HDR_W-1:0] h;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        h = r[HDR_W-1:0];
        h[58:49] = s[9:0];
        h[68:59] = e[9:0];
        h[102]   = part;
        h[103]   = cont;
        return h;
    endfunction

    function automatic int exp_len(input logic [HDR_W-1:0] h);
        int s, e;
        s = int'(h[58:49]);
        e = int'(h[68:59]);
        return ((e - s + 1024) % 1024) + 1;
    endfunction

    function automatic logic [HDR_W-1:0] dut_fields();
        return {ob.continued_wfm, ob.partial_wfm, ob.local_coinc, ob.bsum_valid, ob.bsum_len_sel,
                ob.bsum, ob.sync_rdy, ob.pre_conf, ob.cnst_run, ob.trig_src, ob.stop_addr,
                ob.start_addr, ob.evt_ltc};
    endfunction

    // One clock: compare DUT against the reference mid-cycle, advance the reference,
    // then let the FIFOs pop whatever the DUT requested at the edge.
    task automatic tick();
        logic [NUM_CH-1:0] exp_rd, set, rd_snap;
        bit ld;
        int g;
        @(negedge clk);
        rd_snap = '0;
        if (!rst) begin
            rd_snap = hdr_rdreq;
            checks++;
            if (ob.out_valid !== m_ov) begin
                failures++; $display("FAIL sb_out_valid got=%0d exp=%0d t=%0t", ob.out_valid, m_ov, $time);
            end
            if (m_ov) begin
                checks++;
                if (ob.out_chan !== CH_W'(m_chan)) begin
                    failures++; $display("FAIL sb_out_chan got=%0d exp=%0d t=%0t", ob.out_chan, m_chan, $time);
                end
                checks++;
                if (dut_fields() !== m_hdr) begin
                    failures++; $display("FAIL sb_fields got=%h exp=%h t=%0t", dut_fields(), m_hdr, $time);
                end
                checks++;
                if (ob.wfm_len !== (ADDR_W+1)'(exp_len(m_hdr))) begin
                    failures++; $display("FAIL sb_wfm_len got=%0d exp=%0d t=%0t", ob.wfm_len, exp_len(m_hdr), $time);
                end
            end
            checks++;
            if (seq_err !== m_seq_err) begin
                failures++; $display("FAIL sb_seq_err got=%h exp=%h t=%0t", seq_err, m_seq_err, $time);
            end
            checks++;
            if (hdr_cnt !== m_cnt) begin
                failures++; $display("FAIL sb_hdr_cnt got=%0d exp=%0d t=%0t", hdr_cnt, m_cnt, $time);
            end
            g = -1;
            ld = (!m_ov || ob.out_ready) && (hdr_valid != '0);
            if (ld)
                for (int i = 1; i <= NUM_CH; i++)
                    if (g < 0 && fifo[(m_rr + i) % NUM_CH].size() != 0) g = (m_rr + i) % NUM_CH;
            exp_rd = '0;
            if (ld) exp_rd[g] = 1'b1;
            checks++;
            if (hdr_rdreq !== exp_rd) begin
                failures++; $display("FAIL sb_hdr_rdreq got=%h exp=%h t=%0t", hdr_rdreq, exp_rd, $time);
            end
            if (m_ov && ob.out_ready && m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
            set = '0;
            if (ld) begin
                m_hdr  = fifo[g][0];
                m_chan = g;
                if (m_hdr[103] != m_exp_cont[g]) set[g] = 1'b1;
                m_exp_cont[g] = m_hdr[102];
                m_ov = 1'b1;
                m_rr = g;
            end else if (ob.out_ready) begin
                m_ov = 1'b0;
            end
            m_seq_err = set | (err_clr ? '0 : m_seq_err);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++)
            if (rd_snap[k] && fifo[k].size() != 0) fifo[k].delete(0);
        refresh();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ob.out_valid !== 1'b0 || ob.out_chan !== '0 || ob.wfm_len !== '0 || dut_fields() !== '0) begin
            failures++; $display("FAIL reset_outputs got=%0d/%0d/%0d/%h exp=0", ob.out_valid, ob.out_chan, ob.wfm_len, dut_fields());
        end
        checks++;
        if (hdr_cnt !== 32'd0 || seq_err !== '0 || hdr_rdreq !== '0) begin
            failures++; $display("FAIL reset_cnt_err got=%0d/%h/%h exp=0", hdr_cnt, seq_err, hdr_rdreq);
        end
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        int exp_o [6];
        exp_o = '{0, 1, 5, 0, 1, 5};
        ob.out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(0, mk(1, 2, 0, 0)); push(1, mk(3, 4, 0, 0)); push(5, mk(5, 6, 0, 0));
        end
        #1;
        checks++;
        if (hdr_rdreq !== NUM_CH'(1)) begin
            failures++; $display("FAIL rr_first_grant got=%h exp=%h", hdr_rdreq, NUM_CH'(1));
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ob.out_valid !== 1'b1 || ob.out_chan !== CH_W'(exp_o[i])) begin
                failures++; $display("FAIL rr_order[%0d] got=%0d/%0d exp=1/%0d", i, ob.out_valid, ob.out_chan, exp_o[i]);
            end
        end
        tick();
    endtask

    task automatic test_single();
        logic [HDR_W-1:0] h;
        ob.out_ready = 1'b1;
        h = mk(100, 199, 0, 0);
        push(3, h);
        #1;
        checks++;
        if (hdr_rdreq !== NUM_CH'(8)) begin
            failures++; $display("FAIL single_rdreq got=%h exp=8", hdr_rdreq);
        end
        tick();
        checks++;
        if (ob.out_valid !== 1'b1 || ob.out_chan !== CH_W'(3) || ob.wfm_len !== 11'd100 || ob.evt_ltc !== h[48:0]) begin
            failures++; $display("FAIL single_out got=%0d/%0d/%0d/%h exp=1/3/100/%h", ob.out_valid, ob.out_chan, ob.wfm_len, ob.evt_ltc, h[48:0]);
        end
        #1;
        checks++;
        if (hdr_rdreq !== '0) begin
            failures++; $display("FAIL single_no_repop got=%h exp=0", hdr_rdreq);
        end
        tick();
        checks++;
        if (ob.out_valid !== 1'b0 || ob.evt_ltc !== h[48:0]) begin
            failures++; $display("FAIL single_drain got=%0d/%h exp=0/%h", ob.out_valid, ob.evt_ltc, h[48:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [HDR_W-1:0] h;
        ob.out_ready = 1'b1;
        h = mk(30, 40, 0, 0);
        push(2, h);
        tick();
        ob.out_ready = 1'b0;
        push(4, mk(1, 1, 0, 0));
        push(1, mk(2, 2, 0, 0));
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (hdr_rdreq !== '0 || ob.out_valid !== 1'b1 || ob.out_chan !== CH_W'(2) || dut_fields() !== h) begin
                failures++; $display("FAIL bp_hold[%0d] got=%h/%0d/%0d exp=0/1/2", i, hdr_rdreq, ob.out_valid, ob.out_chan);
            end
            tick();
        end
        ob.out_ready = 1'b1;
        #1;
        checks++;
        if (hdr_rdreq !== NUM_CH'(1 << 4)) begin
            failures++; $display("FAIL bp_release_grant got=%h exp=%h", hdr_rdreq, NUM_CH'(1 << 4));
        end
        tick();
        checks++;
        if (ob.out_chan !== CH_W'(4)) begin
            failures++; $display("FAIL bp_next_chan got=%0d exp=4", ob.out_chan);
        end
        tick();
        checks++;
        if (ob.out_chan !== CH_W'(1)) begin
            failures++; $display("FAIL bp_wrap_chan got=%0d exp=1", ob.out_chan);
        end
        tick();
    endtask

    task automatic test_wfm_len();
        int s [3];
        int e [3];
        int l [3];
        s = '{1000, 7, 0};
        e = '{20, 7, 1023};
        l = '{45, 1, 1024};
        ob.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0, mk(s[i], e[i], 0, 0));
            tick();
            checks++;
            if (ob.wfm_len !== (ADDR_W+1)'(l[i])) begin
                failures++; $display("FAIL wfm_len[%0d] got=%0d exp=%0d", i, ob.wfm_len, l[i]);
            end
        end
        tick();
    endtask

    task automatic test_seq_err();
        ob.out_ready = 1'b1;
        err_clr = 1'b0;
        push(2, mk(10, 20, 1, 0));
        tick();
        checks++;
        if (seq_err !== '0) begin
            failures++; $display("FAIL seq_partial got=%h exp=0", seq_err);
        end
        push(2, mk(21, 30, 0, 0));
        tick();
        checks++;
        if (seq_err !== NUM_CH'(1 << 2)) begin
            failures++; $display("FAIL seq_missing_cont got=%h exp=%h", seq_err, NUM_CH'(1 << 2));
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (seq_err !== '0) begin
            failures++; $display("FAIL seq_clear got=%h exp=0", seq_err);
        end
        push(4, mk(5, 9, 0, 1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (seq_err !== NUM_CH'(1 << 4)) begin
            failures++; $display("FAIL seq_set_over_clear got=%h exp=%h", seq_err, NUM_CH'(1 << 4));
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_random();
        bit busy;
        int ch;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                ch = $urandom_range(0, 7) * 3;
                if (fifo[ch].size() < 4)
                    push(ch, mk($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 1'($urandom)));
            end
            ob.out_ready = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        ob.out_ready = 1'b1;
        err_clr = 1'b0;
        busy = 1'b1;
        for (int i = 0; i < 200 && busy; i++) begin
            tick();
            busy = ob.out_valid;
            for (int k = 0; k < NUM_CH; k++) if (fifo[k].size() != 0) busy = 1'b1;
        end
        checks++;
        if (busy) begin
            failures++; $display("FAIL random_drain got=busy exp=idle");
        end
    endtask

    task automatic test_reset_mid();
        ob.out_ready = 1'b1;
        push(1, mk(50, 60, 0, 0));
        tick();
        ob.out_ready = 1'b0;
        tick();
        flush();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ob.out_valid !== 1'b0 || hdr_cnt !== 32'd0 || ob.wfm_len !== '0) begin
            failures++; $display("FAIL mid_reset_async got=%0d/%0d/%0d exp=0/0/0", ob.out_valid, hdr_cnt, ob.wfm_len);
        end
        repeat (2) tick();
        rst = 1'b0;
        ob.out_ready = 1'b1;
        push(3, mk(1, 2, 0, 0));
        push(0, mk(3, 4, 0, 0));
        #1;
        checks++;
        if (hdr_rdreq !== NUM_CH'(1) || hdr_cnt !== 32'd0) begin
            failures++; $display("FAIL mid_reset_first got=%h/%0d exp=1/0", hdr_rdreq, hdr_cnt);
        end
        tick();
        checks++;
        if (ob.out_chan !== CH_W'(0)) begin
            failures++; $display("FAIL mid_reset_chan0 got=%0d exp=0", ob.out_chan);
        end
        tick();
        checks++;
        if (ob.out_chan !== CH_W'(3) || hdr_cnt !== 32'd1) begin
            failures++; $display("FAIL mid_reset_next got=%0d/%0d exp=3/1", ob.out_chan, hdr_cnt);
        end
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ob.out_ready = 1'b0;
        err_clr = 1'b0;
        flush();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_wfm_len();
        test_seq_err();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
